// File: rtl/addsub_pkg.sv
// Shared types for the add/subtract accumulator pipeline: opcode encoding and status flags.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD     = 2'b00,
    OP_SUB     = 2'b01,
    OP_ACC_ADD = 2'b10,
    OP_ACC_SUB = 2'b11
  } op_t;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic negative;
  } flags_t;

  function automatic logic is_acc(input op_t op);
    return (op == OP_ACC_ADD) || (op == OP_ACC_SUB);
  endfunction

  function automatic logic is_sub(input op_t op);
    return (op == OP_SUB) || (op == OP_ACC_SUB);
  endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational add/subtract with carry/borrow, signed overflow and optional signed saturation.
module addsub_core
  import addsub_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] r,
  output flags_t           flags
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] raw;
  logic             ovf;

  always_comb begin
    // Subtraction is x + ~y + 1, so bit WIDTH is the inverted borrow.
    if (sub) begin
      sum = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
    end else begin
      sum = {1'b0, x} + {1'b0, y};
    end
    raw = sum[MSB:0];
    if (sub) begin
      ovf = (x[MSB] != y[MSB]) && (raw[MSB] != x[MSB]);
    end else begin
      ovf = (x[MSB] == y[MSB]) && (raw[MSB] != x[MSB]);
    end
    r = raw;
    if (SATURATE && ovf) begin
      r = x[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
    end
    flags.zero     = (r == '0);
    flags.carry    = sub ? ~sum[WIDTH] : sum[WIDTH];
    flags.overflow = ovf;
    flags.negative = r[MSB];
  end

endmodule

// File: rtl/addsub_acc_pipe.sv
// Two-stage pipelined add/subtract unit with status flags and a running accumulator.
module addsub_acc_pipe
  import addsub_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             result_is_zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative,
  output logic [WIDTH-1:0] acc
);

  // Handshake: a beat moves on any rising edge where valid && ready. The producer holds
  // op/a/b while in_valid && !in_ready; this unit holds out/flags while out_valid && !out_ready.
  // in_ready is combinational from out_ready (no skid buffer), so a full pipe holds two beats.

  logic             s1_valid;
  op_t              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic             s2_valid;
  flags_t           s2_flags;

  logic             s1_adv;
  logic             s2_adv;

  logic [WIDTH-1:0] core_x;
  logic [WIDTH-1:0] core_y;
  logic [WIDTH-1:0] core_r;
  flags_t           core_flags;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Accumulate ops use acc as the left operand and a as the right; b is ignored.
  assign core_x = is_acc(s1_op) ? acc  : s1_a;
  assign core_y = is_acc(s1_op) ? s1_a : s1_b;

  addsub_core #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE)
  ) u_core (
    .x     (core_x),
    .y     (core_y),
    .sub   (is_sub(s1_op)),
    .r     (core_r),
    .flags (core_flags)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
      s2_valid <= 1'b0;
      s2_flags <= '0;
      out      <= '0;
      acc      <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op <= op;
          s1_a  <= a;
          s1_b  <= b;
        end
      end
      // acc is written on the same edge the result enters S2, so a following ACC op
      // already sitting in S1 sees the updated value next cycle.
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out      <= core_r;
          s2_flags <= core_flags;
          if (is_acc(s1_op)) begin
            acc <= core_r;
          end
        end
      end
    end
  end

  assign out_valid      = s2_valid;
  assign result_is_zero = s2_flags.zero;
  assign carry          = s2_flags.carry;
  assign overflow       = s2_flags.overflow;
  assign negative       = s2_flags.negative;

endmodule

// File: tb/tb_addsub_acc_pipe.sv
// Directed bench for addsub_acc_pipe: wrapping and saturating instances share one stimulus stream.
module tb_addsub_acc_pipe;
  import addsub_pkg::*;

  localparam int W  = 8;
  localparam int EW = 2 * W + 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid;
  logic         out_ready;
  op_t          op;
  logic [W-1:0] a;
  logic [W-1:0] b;

  logic         in_ready0, out_valid0, z0, c0, v0, n0;
  logic [W-1:0] out0, acc0;
  logic         in_ready1, out_valid1, z1, c1, v1, n1;
  logic [W-1:0] out1, acc1;

  addsub_acc_pipe #(.WIDTH(W), .SATURATE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .op(op), .a(a), .b(b),
    .out_valid(out_valid0), .out_ready(out_ready), .out(out0), .result_is_zero(z0),
    .carry(c0), .overflow(v0), .negative(n0), .acc(acc0)
  );

  addsub_acc_pipe #(.WIDTH(W), .SATURATE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1), .op(op), .a(a), .b(b),
    .out_valid(out_valid1), .out_ready(out_ready), .out(out1), .result_is_zero(z1),
    .carry(c1), .overflow(v1), .negative(n1), .acc(acc1)
  );

  // Beat record: {acc, out, zero, carry, overflow, negative}
  logic [EW-1:0] obs0, obs1;
  assign obs0 = {acc0, out0, z0, c0, v0, n0};
  assign obs1 = {acc1, out1, z1, c1, v1, n1};

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  int n_vec = 0;
  int n_bad = 0;
  int beat_no = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [EW-1:0] ev(input logic [W-1:0] acc_v, input logic [W-1:0] out_v,
                                       input logic [3:0] zcvn);
    return {acc_v, out_v, zcvn};
  endfunction

  logic [EW-1:0] held0, held1;
  bit stalled = 1'b0;

  always begin
    @(negedge clk);
    #2;
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (stalled && out_valid0) begin
        check("hold0", 32'(obs0), 32'(held0));
        check("hold1", 32'(obs1), 32'(held1));
      end
      stalled = 1'b0;
      if (out_valid0 !== out_valid1) check("valid_pair", 32'(out_valid1), 32'(out_valid0));
      if (out_ready) begin
        if (out_valid0) begin
          if (exp_q0.size() == 0) check("spurious0", 1, 0);
          else check($sformatf("beat0_%0d", beat_no), 32'(obs0), 32'(exp_q0.pop_front()));
        end
        if (out_valid1) begin
          if (exp_q1.size() == 0) check("spurious1", 1, 0);
          else check($sformatf("beat1_%0d", beat_no), 32'(obs1), 32'(exp_q1.pop_front()));
        end
        if (out_valid0 || out_valid1) beat_no++;
      end else if (out_valid0) begin
        stalled = 1'b1;
        held0   = obs0;
        held1   = obs1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input op_t o, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [EW-1:0] e0, input logic [EW-1:0] e1, input bit track);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    a  = av;
    b  = bv;
    #1;
    while (!in_ready0 && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready0) begin
      check("in_ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    if (track) begin
      exp_q0.push_back(e0);
      exp_q1.push_back(e1);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    if (exp_q0.size() != 0) check("drain_timeout", 32'(exp_q0.size()), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid0"}, 32'(out_valid0), 0);
    check({tag, "_ready0"}, 32'(in_ready0), 1);
    check({tag, "_beat0"},  32'(obs0), 0);
    check({tag, "_valid1"}, 32'(out_valid1), 0);
    check({tag, "_beat1"},  32'(obs1), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    in_valid  = 1'b0;
    op        = OP_ADD;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #3;
    check_idle("reset");

    // ADD / SUB basics and two-cycle latency
    send(OP_ADD, 8'h03, 8'h03, ev(8'h00, 8'h06, 4'b0000), ev(8'h00, 8'h06, 4'b0000), 1'b1);
    @(negedge clk);
    #3 check("latency_c1", 32'(out_valid0), 0);
    @(negedge clk);
    #3 check("latency_c2", 32'(out_valid0), 1);
    send(OP_SUB, 8'h03, 8'h03, ev(8'h00, 8'h00, 4'b1000), ev(8'h00, 8'h00, 4'b1000), 1'b1);

    // borrow, carry-to-zero, negative
    send(OP_SUB, 8'h03, 8'h04, ev(8'h00, 8'hFF, 4'b0101), ev(8'h00, 8'hFF, 4'b0101), 1'b1);
    send(OP_ADD, 8'hFD, 8'h03, ev(8'h00, 8'h00, 4'b1100), ev(8'h00, 8'h00, 4'b1100), 1'b1);
    send(OP_SUB, 8'hFD, 8'h04, ev(8'h00, 8'hF9, 4'b0001), ev(8'h00, 8'hF9, 4'b0001), 1'b1);

    // signed overflow: wrap vs saturate
    send(OP_ADD, 8'h7F, 8'h01, ev(8'h00, 8'h80, 4'b0011), ev(8'h00, 8'h7F, 4'b0010), 1'b1);
    send(OP_SUB, 8'h80, 8'h01, ev(8'h00, 8'h7F, 4'b0010), ev(8'h00, 8'h80, 4'b0011), 1'b1);
    send(OP_ADD, 8'h80, 8'h80, ev(8'h00, 8'h00, 4'b1110), ev(8'h00, 8'h80, 4'b0111), 1'b1);

    // back-to-back accumulate; b is junk and must be ignored
    send(OP_ACC_ADD, 8'h05, 8'hAA, ev(8'h05, 8'h05, 4'b0000), ev(8'h05, 8'h05, 4'b0000), 1'b1);
    send(OP_ACC_ADD, 8'h05, 8'h55, ev(8'h0A, 8'h0A, 4'b0000), ev(8'h0A, 8'h0A, 4'b0000), 1'b1);
    send(OP_ACC_ADD, 8'h05, 8'hAA, ev(8'h0F, 8'h0F, 4'b0000), ev(8'h0F, 8'h0F, 4'b0000), 1'b1);
    send(OP_ACC_SUB, 8'h14, 8'h55, ev(8'hFB, 8'hFB, 4'b0101), ev(8'hFB, 8'hFB, 4'b0101), 1'b1);
    drain();
    check("acc_after_acc0", 32'(acc0), 32'h0FB);
    check("acc_after_acc1", 32'(acc1), 32'h0FB);

    // stream of 6 beats with out_ready low in cycles 3..5
    fork
      begin
        for (int i = 1; i <= 6; i++) begin
          send(OP_ADD, 8'(i), 8'h10, ev(8'hFB, 8'(8'h10 + 8'(i)), 4'b0000),
               ev(8'hFB, 8'(8'h10 + 8'(i)), 4'b0000), 1'b1);
        end
      end
      begin
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          out_ready = !(k >= 3 && k <= 5);
          if (k == 4) begin
            #3 check("stall_in_ready", 32'(in_ready0), 0);
          end
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // bring acc to 0x0F, then reset with two beats in flight
    send(OP_ACC_ADD, 8'h14, 8'h00, ev(8'h0F, 8'h0F, 4'b0100), ev(8'h0F, 8'h0F, 4'b0100), 1'b1);
    drain();
    out_ready = 1'b0;
    send(OP_ADD, 8'h09, 8'h09, '0, '0, 1'b0);
    send(OP_SUB, 8'h01, 8'h01, '0, '0, 1'b0);
    @(negedge clk);
    #3;
    check("inflight_valid", 32'(out_valid0), 1);
    check("inflight_acc", 32'(acc0), 32'h0F);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    @(negedge clk);
    #3;
    check_idle("midreset");
    out_ready = 1'b1;
    send(OP_ACC_ADD, 8'h01, 8'h00, ev(8'h01, 8'h01, 4'b0000), ev(8'h01, 8'h01, 4'b0000), 1'b1);
    drain();
    repeat (3) @(posedge clk);

    check("leftover0", 32'(exp_q0.size()), 0);
    check("leftover1", 32'(exp_q1.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
